// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and default widths for the two-port memory arbiter.
//   state_e : arbiter FSM states (IDLE, BUSY, DONE)
//   owner_e : which requester owns the current access (OWN_IF, OWN_D)
//   DEF_*   : default parameter values for mem_port_arbiter
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // OWN_D encodes as 0 so that a cleared last-owner register reads
    // "data served last", which hands the first round-robin tie to fetch.
    typedef enum logic {
        OWN_IF = 1'b1,
        OWN_D  = 1'b0
    } owner_e;

endpackage

// File: rtl/mem_arb_select.sv
// ----------------------------------------------------------------------------
// mem_arb_select
// Winner selection between the fetch and data requesters.
// Default build: data-first fixed priority, purely combinational.
// With MEM_ARB_RR_EN defined: round-robin using a 1-bit last-owner register;
// on a tie the side not served last wins, fetch wins the first tie after reset.
//
// Ports:
//   clk, reset  : clock and synchronous active-high reset (RR pointer only)
//   if_req_i    : fetch request
//   d_req_i     : data request
//   grant_i     : the top accepted winner_o this cycle (updates RR pointer)
//   any_req_o   : at least one request is pending
//   winner_o    : selected owner (owner_e encoding)
// ----------------------------------------------------------------------------
module mem_arb_select
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic if_req_i,
    input  logic d_req_i,
    input  logic grant_i,
    output logic any_req_o,
    output logic winner_o
);

    assign any_req_o = if_req_i | d_req_i;

`ifdef MEM_ARB_RR_EN
    owner_e last_q;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= OWN_D;
        end else if (grant_i) begin
            last_q <= owner_e'(winner_o);
        end
    end

    always_comb begin
        if (if_req_i && d_req_i) begin
            winner_o = (last_q == OWN_IF) ? OWN_D : OWN_IF;
        end else begin
            winner_o = d_req_i ? OWN_D : OWN_IF;
        end
    end
`else
    // Fixed priority has no state; clock, reset and grant are not needed.
    logic unused_rr;
    assign unused_rr = ^{clk, reset, grant_i};

    assign winner_o = d_req_i ? OWN_D : OWN_IF;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between an instruction-fetch and a data requester.
// IDLE picks a winner and latches its request, BUSY drives the memory from
// the latched copy until mem_ready or timeout, DONE pulses the owner's done.
// Optional feature macro: MEM_ARB_RR_EN (round-robin instead of data-first).
//
// Ports:
//   clk, reset                          : clock, synchronous active-high reset
//   if_req, if_addr                     : fetch request (held until if_done)
//   if_rdata, if_done                   : fetch data, one-cycle completion
//   d_req, d_we, d_addr, d_wdata        : data request (d_we=1 is a write)
//   d_rdata, d_done                     : data read data, one-cycle completion
//   mem_enable, mem_r_w, mem_address,
//   mem_input                           : memory command (mem_r_w=1 is write)
//   mem_output, mem_ready               : memory read data, access complete
//   err                                 : one-cycle pulse on timeout
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_enable,
    output logic              mem_r_w,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_input,
    input  logic [DATA_W-1:0] mem_output,
    input  logic              mem_ready,
    output logic              err
);

    localparam int              CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q,    state_d;
    owner_e            owner_q,    owner_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic              we_q,       we_d;
    logic [CNT_W-1:0]  wait_q,     wait_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,  d_rdata_d;
    logic              if_done_q,  if_done_d;
    logic              d_done_q,   d_done_d;
    logic              err_q,      err_d;

    logic any_req;
    logic winner;
    logic grant;

    mem_arb_select u_select (
        .clk       (clk),
        .reset     (reset),
        .if_req_i  (if_req),
        .d_req_i   (d_req),
        .grant_i   (grant),
        .any_req_o (any_req),
        .winner_o  (winner)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        wait_d     = wait_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_done_d  = 1'b0;
        d_done_d   = 1'b0;
        err_d      = 1'b0;
        grant      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // After a timeout the owner sees done while we are already in
                // IDLE; hold off one cycle so its still-high request is not
                // granted again.
                if (any_req && !(if_done_q || d_done_q)) begin
                    grant   = 1'b1;
                    owner_d = owner_e'(winner);
                    wait_d  = '0;
                    state_d = BUSY;
                    if (owner_e'(winner) == OWN_D) begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        we_d    = d_we;
                    end else begin
                        addr_d  = if_addr;
                        wdata_d = '0;
                        we_d    = 1'b0;
                    end
                end
            end

            BUSY: begin
                if (mem_ready) begin
                    if (owner_q == OWN_D) begin
                        d_done_d = 1'b1;
                        if (!we_q) d_rdata_d = mem_output;
                    end else begin
                        if_done_d = 1'b1;
                        if (!we_q) if_rdata_d = mem_output;
                    end
                    state_d = DONE;
                end else if (wait_q == WAIT_LAST) begin
                    err_d     = 1'b1;
                    d_done_d  = (owner_q == OWN_D);
                    if_done_d = (owner_q == OWN_IF);
                    state_d   = IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_D;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            wait_q     <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            wait_q     <= wait_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
            err_q      <= err_d;
        end
    end

    // The memory command comes only from the latched request registers.
    assign mem_enable  = (state_q == BUSY);
    assign mem_r_w     = mem_enable & we_q;
    assign mem_address = addr_q;
    assign mem_input   = wdata_q;

    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign if_done  = if_done_q;
    assign d_done   = d_done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter (built with TIMEOUT=4).
// A memory responder answers each access after a chosen number of BUSY
// cycles; a transaction-level model predicts latency, owner order and the
// read-data registers. Outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          mem_enable;
    logic          mem_r_w;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_input;
    logic [DW-1:0] mem_output;
    logic          mem_ready;
    logic          err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_done     (if_done),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_done      (d_done),
        .mem_enable  (mem_enable),
        .mem_r_w     (mem_r_w),
        .mem_address (mem_address),
        .mem_input   (mem_input),
        .mem_output  (mem_output),
        .mem_ready   (mem_ready),
        .err         (err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Responder control: ready on BUSY cycle number ready_delay (0-based),
    // never when negative.
    int          ready_delay = 0;
    bit          data_ovr_en = 1'b0;
    logic [31:0] data_ovr    = 32'h0;

    // Transaction-level model state.
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;
    bit          last_d;   // 1: data side was served last

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // Memory responder; toggles mem_ready randomly outside BUSY.
    initial begin : mem_model
        int busy_cnt;
        busy_cnt   = 0;
        mem_ready  = 1'b0;
        mem_output = '0;
        forever begin
            @(negedge clk);
            if (mem_enable === 1'b1) begin
                if (ready_delay >= 0 && busy_cnt == ready_delay) begin
                    mem_ready  = 1'b1;
                    mem_output = data_ovr_en ? data_ovr : mem_fn(mem_address);
                end else begin
                    mem_ready  = 1'b0;
                    mem_output = $urandom;
                end
                busy_cnt++;
            end else begin
                busy_cnt   = 0;
                mem_ready  = 1'($urandom_range(0, 1));
                mem_output = $urandom;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One access on one side; reports what the memory port and done saw.
    task automatic access(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit wiggle,
                          input logic [31:0] alt_addr,
                          output int lat, output int busy_n,
                          output logic [31:0] s_addr, output logic s_rw,
                          output logic [31:0] s_wdata, output bit stable,
                          output bit s_err, output bit other_done,
                          output bit en_at_done);
        bit first;
        bit got;
        first = 1'b1; got = 1'b0; lat = 1; busy_n = 0; stable = 1'b1;
        s_err = 1'b0; other_done = 1'b0; en_at_done = 1'b1;
        s_addr = '0; s_rw = 1'b0; s_wdata = '0;
        if (is_d) begin
            d_addr = addr; d_we = we; d_wdata = wdata; d_req = 1'b1;
        end else begin
            if_addr = addr; if_req = 1'b1;
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            lat++;
            if ((is_d ? if_done : d_done) === 1'b1) other_done = 1'b1;
            if (mem_enable === 1'b1) begin
                busy_n++;
                if (first) begin
                    s_addr = mem_address; s_rw = mem_r_w; s_wdata = mem_input;
                    first = 1'b0;
                end else if (mem_address !== s_addr || mem_r_w !== s_rw ||
                             mem_input !== s_wdata) begin
                    stable = 1'b0;
                end
                if (wiggle) begin
                    if (is_d) begin
                        d_addr = alt_addr; d_we = ~we; d_wdata = $urandom;
                    end else begin
                        if_addr = alt_addr;
                    end
                end
            end
            if ((is_d ? d_done : if_done) === 1'b1) begin
                s_err = err; en_at_done = mem_enable; got = 1'b1;
                break;
            end
        end
        if (!got) lat = -1;
        if (is_d) d_req = 1'b0; else if_req = 1'b0;
    endtask

    task automatic model_reset();
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        last_d       = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (mem_enable !== 1'b0) $display("FAIL reset_mem_enable: got %b want 0", mem_enable); else n_pass++;
        n_checks++; if (mem_r_w !== 1'b0) $display("FAIL reset_mem_r_w: got %b want 0", mem_r_w); else n_pass++;
        n_checks++; if (mem_address !== '0) $display("FAIL reset_mem_address: got %h want 0", mem_address); else n_pass++;
        n_checks++; if (mem_input !== '0) $display("FAIL reset_mem_input: got %h want 0", mem_input); else n_pass++;
        n_checks++; if ({if_done, d_done, err} !== 3'b000) $display("FAIL reset_pulses: got %b want 000", {if_done, d_done, err}); else n_pass++;
        n_checks++; if (if_rdata !== '0 || d_rdata !== '0) $display("FAIL reset_rdata: got %h/%h want 0/0", if_rdata, d_rdata); else n_pass++;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single_fetch();
        ready_delay = 0; data_ovr_en = 1'b1; data_ovr = 32'hDEAD_BEEF;
        if_addr = 32'h100; if_req = 1'b1;
        @(negedge clk);   // cycle 2: BUSY
        n_checks++; if (mem_enable !== 1'b1 || mem_address !== 32'h100 || mem_r_w !== 1'b0)
            $display("FAIL fetch_busy: got en=%b addr=%h rw=%b want 1/100/0", mem_enable, mem_address, mem_r_w); else n_pass++;
        n_checks++; if (if_done !== 1'b0) $display("FAIL fetch_early_done: got %b want 0", if_done); else n_pass++;
        @(negedge clk);   // cycle 3: DONE
        n_checks++; if (if_done !== 1'b1 || d_done !== 1'b0 || err !== 1'b0 || mem_enable !== 1'b0)
            $display("FAIL fetch_done_c3: got if_done=%b d_done=%b err=%b en=%b want 1/0/0/0", if_done, d_done, err, mem_enable); else n_pass++;
        n_checks++; if (if_rdata !== 32'hDEAD_BEEF) $display("FAIL fetch_rdata: got %h want deadbeef", if_rdata); else n_pass++;
        if_req = 1'b0;
        @(negedge clk);
        n_checks++; if (if_done !== 1'b0) $display("FAIL fetch_done_width: got %b want 0", if_done); else n_pass++;
        data_ovr_en = 1'b0;
        exp_if_rdata = 32'hDEAD_BEEF; last_d = 1'b0;
    endtask

    task automatic test_data_write();
        int lat, bn; logic [31:0] sa, sw; logic srw; bit st, se, od, ed;
        ready_delay = 1;
        access(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, lat, bn, sa, srw, sw, st, se, od, ed);
        exp_d_rdata = mem_fn(32'h40); last_d = 1'b1;
        n_checks++; if (lat !== 4 || d_rdata !== exp_d_rdata)
            $display("FAIL dread_pre: got lat=%0d rdata=%h want 4/%h", lat, d_rdata, exp_d_rdata); else n_pass++;
        @(negedge clk);
        ready_delay = 0;
        access(1'b1, 1'b1, 32'h2000, 32'h55, 1'b0, 32'h0, lat, bn, sa, srw, sw, st, se, od, ed);
        n_checks++; if (srw !== 1'b1 || sw !== 32'h55 || sa !== 32'h2000)
            $display("FAIL dwrite_port: got rw=%b wdata=%h addr=%h want 1/55/2000", srw, sw, sa); else n_pass++;
        n_checks++; if (lat !== 3 || se !== 1'b0 || od !== 1'b0)
            $display("FAIL dwrite_done: got lat=%0d err=%b other=%b want 3/0/0", lat, se, od); else n_pass++;
        n_checks++; if (d_rdata !== exp_d_rdata) $display("FAIL dwrite_rdata_kept: got %h want %h", d_rdata, exp_d_rdata); else n_pass++;
        @(negedge clk);
        n_checks++; if (d_done !== 1'b0) $display("FAIL dwrite_done_once: got %b want 0", d_done); else n_pass++;
    endtask

    task automatic test_addr_change();
        int lat, bn; logic [31:0] sa, sw; logic srw; bit st, se, od, ed;
        ready_delay = 2;
        access(1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 32'h200, lat, bn, sa, srw, sw, st, se, od, ed);
        exp_if_rdata = mem_fn(32'h100); last_d = 1'b0;
        n_checks++; if (sa !== 32'h100 || st !== 1'b1)
            $display("FAIL addr_change: got addr=%h stable=%b want 100/1", sa, st); else n_pass++;
        n_checks++; if (lat !== 5 || if_rdata !== exp_if_rdata)
            $display("FAIL addr_change_data: got lat=%0d rdata=%h want 5/%h", lat, if_rdata, exp_if_rdata); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int lat, bn; logic [31:0] sa, sw; logic srw; bit st, se, od, ed;
        ready_delay = -1;
        access(1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0, lat, bn, sa, srw, sw, st, se, od, ed);
        last_d = 1'b1;
        n_checks++; if (bn !== TO || lat !== TO + 2)
            $display("FAIL timeout_len: got busy=%0d lat=%0d want %0d/%0d", bn, lat, TO, TO + 2); else n_pass++;
        n_checks++; if (se !== 1'b1 || ed !== 1'b0)
            $display("FAIL timeout_err: got err=%b en=%b want 1/0", se, ed); else n_pass++;
        n_checks++; if (d_rdata !== exp_d_rdata) $display("FAIL timeout_rdata: got %h want %h", d_rdata, exp_d_rdata); else n_pass++;
        @(negedge clk);
        n_checks++; if (err !== 1'b0 || d_done !== 1'b0 || mem_enable !== 1'b0)
            $display("FAIL timeout_after: got err=%b done=%b en=%b want 0/0/0", err, d_done, mem_enable); else n_pass++;
        ready_delay = 0;
    endtask

    task automatic test_simultaneous();
        bit order[$];
        bit exp_first;
        bit both_flag;
        int cyc;
        logic [31:0] ia, da;
        ready_delay = 0;
        for (int k = 0; k < 2; k++) begin
            exp_first = RR ? !last_d : 1'b1;
            ia = $urandom; da = $urandom;
            order.delete(); both_flag = 1'b0; cyc = 1;
            if_addr = ia; if_req = 1'b1;
            d_addr = da; d_we = 1'b0; d_req = 1'b1;
            for (int c = 0; c < 40 && order.size() < 2; c++) begin
                @(negedge clk);
                cyc++;
                if (if_done === 1'b1 && d_done === 1'b1) both_flag = 1'b1;
                if (if_done === 1'b1) begin order.push_back(1'b0); if_req = 1'b0; end
                if (d_done === 1'b1) begin order.push_back(1'b1); d_req = 1'b0; end
            end
            if_req = 1'b0; d_req = 1'b0;
            n_checks++;
            if (order.size() != 2 || both_flag || order[0] !== exp_first || order[1] !== !exp_first)
                $display("FAIL simul_order round %0d: got n=%0d first_d=%b want first_d=%b", k, order.size(),
                         (order.size() > 0) ? order[0] : 1'b0, exp_first);
            else n_pass++;
            n_checks++; if (cyc !== 6) $display("FAIL simul_latency round %0d: got %0d want 6", k, cyc); else n_pass++;
            exp_if_rdata = mem_fn(ia); exp_d_rdata = mem_fn(da); last_d = !exp_first;
            n_checks++; if (if_rdata !== exp_if_rdata || d_rdata !== exp_d_rdata)
                $display("FAIL simul_rdata round %0d: got %h/%h want %h/%h", k, if_rdata, d_rdata, exp_if_rdata, exp_d_rdata); else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int lat, bn; logic [31:0] sa, sw; logic srw; bit st, se, od, ed;
        bit is_d, we, wig; logic [31:0] addr, wdata, alt; int dly;
        for (int i = 0; i < 24; i++) begin
            is_d = 1'($urandom_range(0, 1));
            we   = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
            addr = $urandom; wdata = $urandom; alt = $urandom;
            wig  = 1'($urandom_range(0, 1));
            dly  = $urandom_range(0, TO - 1);
            ready_delay = dly;
            access(is_d, we, addr, wdata, wig, alt, lat, bn, sa, srw, sw, st, se, od, ed);
            if (!we) begin
                if (is_d) exp_d_rdata = mem_fn(addr); else exp_if_rdata = mem_fn(addr);
            end
            last_d = is_d;
            n_checks++; if (lat !== 3 + dly || bn !== dly + 1)
                $display("FAIL rand_lat iter %0d: got lat=%0d busy=%0d want %0d/%0d", i, lat, bn, 3 + dly, dly + 1); else n_pass++;
            n_checks++; if (sa !== addr || srw !== we || (we && sw !== wdata) || !st)
                $display("FAIL rand_port iter %0d: got addr=%h rw=%b wd=%h st=%b want %h/%b/%h/1", i, sa, srw, sw, st, addr, we, wdata); else n_pass++;
            n_checks++; if (se !== 1'b0 || od !== 1'b0)
                $display("FAIL rand_flags iter %0d: got err=%b other=%b want 0/0", i, se, od); else n_pass++;
            n_checks++; if (if_rdata !== exp_if_rdata || d_rdata !== exp_d_rdata)
                $display("FAIL rand_rdata iter %0d: got %h/%h want %h/%h", i, if_rdata, d_rdata, exp_if_rdata, exp_d_rdata); else n_pass++;
            @(negedge clk);
            n_checks++; if ({if_done, d_done, err} !== 3'b000)
                $display("FAIL rand_pulse_width iter %0d: got %b want 000", i, {if_done, d_done, err}); else n_pass++;
        end
        ready_delay = 0;
    endtask

    task automatic test_reset_mid_access();
        int lat, bn; logic [31:0] sa, sw; logic srw; bit st, se, od, ed;
        bit stray;
        ready_delay = -1;
        if_addr = 32'h700; if_req = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (mem_enable !== 1'b1) $display("FAIL rst_mid_busy: got en=%b want 1", mem_enable); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if ({mem_enable, mem_r_w, if_done, d_done, err} !== 5'b0 || mem_address !== '0 || mem_input !== '0)
            $display("FAIL rst_mid_outputs: got ctl=%b addr=%h in=%h want 0", {mem_enable, mem_r_w, if_done, d_done, err}, mem_address, mem_input); else n_pass++;
        n_checks++; if (if_rdata !== '0 || d_rdata !== '0)
            $display("FAIL rst_mid_rdata: got %h/%h want 0/0", if_rdata, d_rdata); else n_pass++;
        reset = 1'b0; if_req = 1'b0;
        model_reset();
        stray = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (if_done !== 1'b0 || d_done !== 1'b0 || err !== 1'b0 || mem_enable !== 1'b0) stray = 1'b1;
        end
        n_checks++; if (stray) $display("FAIL rst_mid_no_done: got activity after reset want none"); else n_pass++;
        ready_delay = 0;
        access(1'b0, 1'b0, 32'h704, 32'h0, 1'b0, 32'h0, lat, bn, sa, srw, sw, st, se, od, ed);
        exp_if_rdata = mem_fn(32'h704); last_d = 1'b0;
        n_checks++; if (lat !== 3 || if_rdata !== exp_if_rdata)
            $display("FAIL rst_mid_recover: got lat=%0d rdata=%h want 3/%h", lat, if_rdata, exp_if_rdata); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_rr_after_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        test_simultaneous();
    endtask

    initial begin : main
        test_reset();
        test_simultaneous();
        test_single_fetch();
        test_data_write();
        test_addr_change();
        test_timeout();
        test_simultaneous();
        test_random();
        test_reset_mid_access();
        test_rr_after_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
